// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial 16-bit subtractor with full and packed-saturating modes
module nibble_serial_sub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pad,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   Diff,
    output logic                   Ovfl,
    output logic                   Zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_pad;
    logic          r_carry;
    logic [W-1:0]  r_diff;
    logic          r_ovfl;
    logic          r_zero;

    logic [3:0]    w_a_lane;
    logic [3:0]    w_b_lane;
    logic          w_cin;
    logic [4:0]    w_sum;
    logic          w_lo;
    logic [3:0]    w_res;
    logic [W-1:0]  w_diff_next;
    logic          w_last;
    logic          w_accept;

    // One shared 4-bit adder: A + ~B + cin, the lane selected by r_cnt.
    always_comb begin
        w_a_lane    = r_a[{r_cnt, 2'b00} +: 4];
        w_b_lane    = r_b[{r_cnt, 2'b00} +: 4];
        w_cin       = (r_pad || (r_cnt == '0)) ? 1'b1 : r_carry;
        w_sum       = {1'b0, w_a_lane} + {1'b0, ~w_b_lane} + {4'b0000, w_cin};
        w_lo        = (w_a_lane[3] != w_b_lane[3]) && (w_sum[3] != w_a_lane[3]);
        w_res       = w_sum[3:0];
        if (r_pad && w_lo) begin
            w_res = w_a_lane[3] ? 4'b1000 : 4'b0111;
        end
        w_diff_next = r_diff;
        w_diff_next[{r_cnt, 2'b00} +: 4] = w_res;
        w_last      = (r_cnt == LAST_LANE);
        w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_pad   <= 1'b0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_ovfl  <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_a     <= A;
            r_b     <= B;
            r_pad   <= pad;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_ovfl  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_sum[4];
                    r_cnt   <= r_cnt + 1'b1;
                    // Full mode reports only the top lane; pad mode accumulates every lane.
                    if (w_last && !r_pad) begin
                        r_ovfl <= w_lo;
                    end else if (r_pad && w_lo) begin
                        r_ovfl <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_zero  <= (w_diff_next == '0);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign Diff = r_diff;
    assign Ovfl = r_ovfl;
    assign Zero = r_zero;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb/tb_nibble_serial_sub.sv - randomized model-checked bench for nibble_serial_sub
module tb_nibble_serial_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pad = 1'b0;
    logic [15:0] A = 16'h0;
    logic [15:0] B = 16'h0;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic        Ovfl;
    logic        Zero;

    int n_checks = 0;
    int n_err    = 0;

    nibble_serial_sub #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pad(pad), .A(A), .B(B),
        .busy(busy), .done(done), .Diff(Diff), .Ovfl(Ovfl), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result {zero, ovfl, diff} from plain signed arithmetic.
    function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic p);
        logic [15:0] d;
        logic        ov;
        int          sa, sb, x;
        d  = 16'h0;
        ov = 1'b0;
        if (!p) begin
            d  = a - b;
            x  = int'($signed(a)) - int'($signed(b));
            ov = (x > 32767) || (x < -32768);
        end else begin
            for (int i = 0; i < 4; i++) begin
                sa = int'(a[4*i +: 4]);
                sb = int'(b[4*i +: 4]);
                if (sa > 7) sa = sa - 16;
                if (sb > 7) sb = sb - 16;
                x = sa - sb;
                if (x > 7) begin
                    x  = 7;
                    ov = 1'b1;
                end else if (x < -8) begin
                    x  = -8;
                    ov = 1'b1;
                end
                d[4*i +: 4] = x[3:0];
            end
        end
        return {(d == 16'h0), ov, d};
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [17:0] m_pend = 18'h0;
    logic [17:0] m_res  = 18'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_pend <= 18'h0;
            m_res  <= 18'h0;
        end else if (!m_busy && start) begin
            m_pend <= ref_sub(A, B, pad);
            m_res  <= 18'h0;
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_left <= 4;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("done", {31'b0, done}, {31'b0, m_done});
        if (!m_busy) begin
            chk("diff", {16'b0, Diff}, {16'b0, m_res[15:0]});
            chk("ovfl", {31'b0, Ovfl}, {31'b0, m_res[16]});
            chk("zero", {31'b0, Zero}, {31'b0, m_res[17]});
        end
    end

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic p);
        @(negedge clk);
        A = a; B = b; pad = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_done_seen"}, {31'b0, got}, 32'd1);
    endtask

    task automatic check_res(input string name, input logic [15:0] ed, input logic eo, input logic ez);
        chk({name, "_diff"}, {16'b0, Diff}, {16'b0, ed});
        chk({name, "_ovfl"}, {31'b0, Ovfl}, {31'b0, eo});
        chk({name, "_zero"}, {31'b0, Zero}, {31'b0, ez});
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b, input logic p,
                          input logic [15:0] ed, input logic eo, input logic ez);
        launch(a, b, p);
        wait_done(name);
        check_res(name, ed, eo, ez);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_diff", {16'b0, Diff}, 32'd0);
        rst = 1'b0;

        run_op("full_borrow", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op("full_ovfl",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
        run_op("full_zero",   16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op("pad_sat",     16'h7180, 16'h8F01, 1'b1, 16'h728F, 1'b1, 1'b0);
        run_op("pad_plain",   16'h3333, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0);
        run_op("pad_neg8",    16'h0000, 16'h8888, 1'b1, 16'h7777, 1'b1, 1'b0);

        // start during RUN with other operands must be ignored
        launch(16'h1234, 16'h0235, 1'b0);
        @(negedge clk);
        A = 16'hFFFF; B = 16'h0001; pad = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        check_res("ignore", 16'h0FFF, 1'b0, 1'b0);

        // start held through DONE chains straight into the next operation
        @(negedge clk);
        A = 16'h8000; B = 16'h0001; pad = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done("b2b_first");
        check_res("b2b_first", 16'h7FFF, 1'b1, 1'b0);
        A = 16'h3333; B = 16'h1111; pad = 1'b1;
        @(negedge clk);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        start = 1'b0;
        wait_done("b2b_second");
        check_res("b2b_second", 16'h2222, 1'b0, 1'b0);

        // asynchronous reset in the middle of RUN
        launch(16'h1234, 16'h0235, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_diff", {16'b0, Diff}, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_done", {31'b0, done}, 32'd0);
        end
        run_op("after_rst", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);

        // randomized traffic, including requests while busy and rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            A     = 16'($urandom);
            B     = 16'($urandom);
            pad   = 1'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle subtractor; the inverse of the 4-bit lookahead adder. Computes Diff = A - B on 16-bit operands, one nibble per clock, through a single 4-bit add datapath (A + ~B + cin).
- Two modes: full 16-bit two's-complement subtract with the borrow chained across nibbles, or packed saturating subtract of four independent signed nibbles (pad).
- Sits beside the ALU as the SUB/PSUBSB engine, with a start/busy/done handshake toward the control unit.

Parameters:
NIBBLES, 4, number of 4-bit lanes processed; the data width is 4*NIBBLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- pad  input  1  1 = packed saturating lanes; 0 = full-width subtract. Latched with start.
- A  input  16  minuend; latched with start.
- B  input  16  subtrahend; latched with start.
- busy  output  1  high while the operation is running.
- done  output  1  one-cycle pulse when Diff is valid.
- Diff  output  16  result; held until the next accepted start.
- Ovfl  output  1  full mode: 16-bit signed overflow. Pad mode: OR of all lane saturations.
- Zero  output  1  Diff == 0; valid alongside done and held with Diff.

Behaviour:
- States: IDLE, RUN, DONE. Lane counter cnt is 2 bits.
- Reset (async, any state): state=IDLE, cnt=0, busy=0, done=0, Diff=0, Ovfl=0, Zero=0, operand/mode registers=0. An operation in flight is discarded and no done is produced.
- IDLE: start=1 at edge E0 latches A, B and pad, clears Diff/Ovfl/Zero, sets cnt=0 and goes to RUN. busy=1 from E0.
- RUN: at each edge, lane cnt is computed and written to Diff[4cnt+3:4cnt], then cnt increments.
- Lane sum: s = A_lane + ~B_lane + cin, a 4-bit sum with carry out c.
- Full mode: cin = 1 for lane 0, otherwise the registered carry out of the previous lane.
- Pad mode: cin = 1 for every lane, with no inter-lane carry.
- Lane overflow: lo = (A_lane[3] != B_lane[3]) & (s[3] != A_lane[3]).
- Pad mode saturation: when lo=1, the lane result is 4'b0111 if A_lane[3]=0, else 4'b1000. The sticky Ovfl is set if any lane has lo=1.
- Full mode Ovfl: taken only from lane 3's lo, using the same formula on bit 15. Carry out of lane 3 is discarded (borrow is not reported).
- The edge that processes lane 3 (E4) moves the state to DONE. Zero is computed from the final Diff on that same edge.
- DONE: busy=0, done=1 for exactly one cycle. The next edge goes to IDLE, or directly into RUN if start=1, giving back-to-back operation with no dead cycle.
- Latency: start at E0, then done=1 during the cycle after E4 (4 cycles), with a throughput of one op per 5 cycles.
- start while busy=1 is ignored; no queuing, and inputs are not re-latched.
- Diff, Ovfl and Zero are stable from done until the next accepted start. Changing A, B or pad mid-op has no effect.
- Arithmetic wraps modulo 2^16 in full mode and never wraps in pad mode.
- Edge case B_lane = 4'b1000 is handled correctly by the lo formula (for example, 0 - (-8) saturates to 0111).

Test Plan:
- Full mode: A=16'h1234, B=16'h0235 -> Diff=16'h0FFF after 4 cycles, borrow propagated lanes 0-2, Ovfl=0, Zero=0, done pulse of 1 cycle.
- Full mode overflow: A=16'h8000, B=16'h0001 -> Diff=16'h7FFF, Ovfl=1. Then A=B=16'hABCD -> Diff=0, Zero=1.
- Pad mode: A=16'h7180, B=16'h8F01 -> lanes give 7-(-8) sat 0111, 1-(-1)=2, -8-0=8 (1000), 0-1=F. Diff=16'h728F, Ovfl=1.
- Pad mode, no saturation: A=16'h3333, B=16'h1111 -> Diff=16'h2222, Ovfl=0. Also 0-(-8): A=16'h0000, B=16'h8888 -> Diff=16'h7777, Ovfl=1.
- Handshake: start re-asserted during RUN with different operands -> ignored, original result returned. start held high in the DONE cycle -> new op begins, busy re-asserts on the next edge.
- Reset mid-op: rst pulsed at cycle 2 of RUN -> busy=0, Diff=0, no done pulse. Next start completes normally.
